// File: rtl/pc_gen.sv
// Fetch program-counter generator: picks the next PC from reset, redirect, stall, BTB or pc+4.
// Define PC_BTB_EN to build the direct-mapped branch target buffer; otherwise prediction is off.
module pc_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned      BTB_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [1:0]       redirect_op,
    input  logic [WIDTH-1:0] br_pc,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs1,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic [WIDTH-1:0] npc,
    output logic             misalign,
    output logic             bp_taken,
    output logic [WIDTH-1:0] bp_target,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_taken
);

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_JAL    = 2'b01;
    localparam logic [1:0] OP_JALR   = 2'b10;
    localparam logic [1:0] OP_TRAP   = 2'b11;

    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);
    localparam logic [WIDTH-1:0] JALR_MASK = ~WIDTH'(1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             misalign_q, misalign_d;

    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jalr_target;
    logic [WIDTH-1:0] redir_target;
    logic             redir_misaligned;

    assign pc4 = pc_q + PC_STEP;

    always_comb begin
        br_target   = br_pc + imm;
        jalr_target = (rs1 + imm) & JALR_MASK;
    end

    always_comb begin
        redir_target     = br_target;
        redir_misaligned = 1'b0;
        case (redirect_op)
            OP_BRANCH: redir_target = br_target;
            OP_JAL:    redir_target = br_target;
            OP_JALR:   redir_target = jalr_target;
            default:   redir_target = TRAP_VEC;
        endcase
        // The trap vector itself is trusted; only computed targets are alignment-checked.
        if ((redirect_op != OP_TRAP) && (redir_target[1:0] != 2'b00)) begin
            redir_misaligned = 1'b1;
        end
    end

    always_comb begin
        pc_d = pc4;
        if (rst) begin
            pc_d = RESET_VEC;
        end else if (redirect_valid) begin
            pc_d = redir_misaligned ? TRAP_VEC : redir_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (bp_taken) begin
            pc_d = bp_target;
        end
    end

    assign misalign_d = redirect_valid & redir_misaligned & ~rst;
    assign npc        = pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign misalign = misalign_q;

`ifdef PC_BTB_EN
    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = WIDTH - IDX_W - 2;

    logic [BTB_DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [TAG_W-1:0]     tag_d [BTB_DEPTH];
    logic [WIDTH-1:0]     tgt_q [BTB_DEPTH];
    logic [WIDTH-1:0]     tgt_d [BTB_DEPTH];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_en;
    logic             unused_upd_lsb;

    assign rd_idx = pc_q[IDX_W+1:2];
    assign rd_tag = pc_q[WIDTH-1:IDX_W+2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[WIDTH-1:IDX_W+2];
    assign wr_en  = upd_valid & upd_taken & ~rst;

    assign unused_upd_lsb = ^upd_pc[1:0];

    // Lookup reads the registered arrays, so a same-edge write is only seen next cycle.
    assign bp_taken  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign bp_target = tgt_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        if (upd_valid) begin
            if (upd_taken) begin
                valid_d[wr_idx] = 1'b1;
            end else if (valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag)) begin
                valid_d[wr_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        tag_d = tag_q;
        tgt_d = tgt_q;
        if (wr_en) begin
            tag_d[wr_idx] = wr_tag;
            tgt_d[wr_idx] = upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target need no reset: they are qualified by the valid bit.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end
`else
    logic unused_upd;
    logic unused_cfg;

    assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign unused_cfg = (BTB_DEPTH != 0);
    assign bp_taken   = 1'b0;
    assign bp_target  = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen; BTB expectations follow whether PC_BTB_EN is defined.
module tb_pc_gen;

    localparam int unsigned W = 32;
`ifdef PC_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         redirect_valid;
    logic [1:0]   redirect_op;
    logic [W-1:0] br_pc, imm, rs1;
    logic [W-1:0] pc, pc4, npc, bp_target;
    logic         misalign, bp_taken;
    logic         upd_valid, upd_taken;
    logic [W-1:0] upd_pc, upd_target;

    pc_gen #(
        .WIDTH    (W),
        .RESET_VEC(32'h0000_0000),
        .TRAP_VEC (32'h0000_0100),
        .BTB_DEPTH(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_op   (redirect_op),
        .br_pc         (br_pc),
        .imm           (imm),
        .rs1           (rs1),
        .pc            (pc),
        .pc4           (pc4),
        .npc           (npc),
        .misalign      (misalign),
        .bp_taken      (bp_taken),
        .bp_target     (bp_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] pc;
        logic         mis;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected post-edge state is queued with the stimulus, then drained once the edge is past.
    task automatic step(input string tag, input logic [W-1:0] exp_pc, input logic exp_mis);
        exp_t e;
        e.tag = tag;
        e.pc  = exp_pc;
        e.mis = exp_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".pc"}, pc, e.pc);
            check({e.tag, ".mis"}, {31'b0, misalign}, {31'b0, e.mis});
        end
    endtask

    task automatic redir(input logic [1:0] op, input logic [W-1:0] b, input logic [W-1:0] im,
                         input logic [W-1:0] r1);
        redirect_valid = 1'b1;
        redirect_op    = op;
        br_pc          = b;
        imm            = im;
        rs1            = r1;
    endtask

    task automatic train(input logic [W-1:0] p, input logic [W-1:0] t, input logic tk);
        upd_valid  = 1'b1;
        upd_pc     = p;
        upd_target = t;
        upd_taken  = tk;
    endtask

    task automatic idle();
        redirect_valid = 1'b0;
        redirect_op    = 2'b00;
        br_pc          = '0;
        imm            = '0;
        rs1            = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_target     = '0;
        upd_taken      = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        idle();

        // Reset and sequential fetch
        step("rst0", 32'h0, 1'b0);
        check("rst_pc4", pc4, 32'h4);
        check("rst_npc", npc, 32'h0);
        check("rst_bp", {31'b0, bp_taken}, 32'h0);
        step("rst1", 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_npc", npc, 32'h4);
        check("post_rst_pc4", pc4, 32'h4);
        step("seq4", 32'h4, 1'b0);
        step("seq8", 32'h8, 1'b0);
        step("seq12", 32'hC, 1'b0);

        // Wrap at the top of the address space
        redir(2'b01, 32'hFFFF_FFF8, 32'h4, 32'h0);
        step("jal_top", 32'hFFFF_FFFC, 1'b0);
        idle();
        #1;
        check("pc4_wrap", pc4, 32'h0);
        step("wrap", 32'h0, 1'b0);

        // Branch redirect beats stall, then stall holds
        redir(2'b01, 32'h30, 32'h10, 32'h0);
        step("jal40", 32'h40, 1'b0);
        stall = 1'b1;
        redir(2'b00, 32'h38, 32'hFFFF_FFF0, 32'h0);
        #1;
        check("npc_br", npc, 32'h28);
        step("br_stall", 32'h28, 1'b0);
        idle();
        #1;
        check("npc_stall", npc, 32'h28);
        for (int i = 0; i < 3; i++) step("stall_hold", 32'h28, 1'b0);
        stall = 1'b0;

        // jalr alignment
        redir(2'b10, 32'h0, 32'h10, 32'h1001);
        step("jalr_ok", 32'h1010, 1'b0);
        redir(2'b10, 32'h0, 32'h10, 32'h1002);
        step("jalr_mis", 32'h100, 1'b1);
        idle();
        step("after_mis", 32'h104, 1'b0);

        // Trap, misaligned branch, back-to-back redirects
        redir(2'b11, 32'h123, 32'h5, 32'h7);
        step("trap", 32'h100, 1'b0);
        redir(2'b00, 32'h100, 32'h2, 32'h0);
        step("br_mis", 32'h100, 1'b1);
        redir(2'b01, 32'h300, 32'h0, 32'h0);
        step("cons0", 32'h300, 1'b0);
        redir(2'b01, 32'h500, 32'h0, 32'h0);
        step("cons1", 32'h500, 1'b0);

        // Reset overrides redirect, fault and BTB training on the same edge
        rst = 1'b1;
        redir(2'b10, 32'h0, 32'h0, 32'h2);
        train(32'h20, 32'h80, 1'b1);
        step("rst_redir", 32'h0, 1'b0);
        rst = 1'b0;
        idle();
        step("rst_rel", 32'h4, 1'b0);
        redir(2'b01, 32'h20, 32'h0, 32'h0);
        step("j20", 32'h20, 1'b0);
        idle();
        check("no_rst_train", {31'b0, bp_taken}, 32'h0);
        step("seq24", 32'h24, 1'b0);

        // Train taken at 0x20
        redir(2'b01, 32'h10, 32'h0, 32'h0);
        train(32'h20, 32'h80, 1'b1);
        step("j10", 32'h10, 1'b0);
        idle();
        step("seq14", 32'h14, 1'b0);
        step("seq18", 32'h18, 1'b0);
        step("seq1c", 32'h1C, 1'b0);
        step("to20", 32'h20, 1'b0);
        check("bp_hit", {31'b0, bp_taken}, {31'b0, BTB});
        check("bp_tgt", bp_target, BTB ? 32'h80 : 32'h0);
        check("npc_pred", npc, BTB ? 32'h80 : 32'h24);
        step("pred20", BTB ? 32'h80 : 32'h24, 1'b0);

        // Untrain with matching tag
        redir(2'b01, 32'h1C, 32'h0, 32'h0);
        train(32'h20, 32'h80, 1'b0);
        step("j1c", 32'h1C, 1'b0);
        idle();
        step("to20b", 32'h20, 1'b0);
        check("bp_clr", {31'b0, bp_taken}, 32'h0);
        step("fall20", 32'h24, 1'b0);

        // Aliasing entry 0x60 replaces 0x20; not-taken with wrong tag must not clear it
        redir(2'b01, 32'h18, 32'h0, 32'h0);
        train(32'h20, 32'h80, 1'b1);
        step("j18", 32'h18, 1'b0);
        idle();
        train(32'h60, 32'h90, 1'b1);
        step("alias_wr", 32'h1C, 1'b0);
        train(32'h20, 32'h0, 1'b0);
        step("to20c", 32'h20, 1'b0);
        idle();
        check("bp_alias", {31'b0, bp_taken}, 32'h0);
        step("fall20b", 32'h24, 1'b0);
        redir(2'b01, 32'h60, 32'h0, 32'h0);
        step("j60", 32'h60, 1'b0);
        idle();
        check("bp_hit60", {31'b0, bp_taken}, {31'b0, BTB});
        check("bp_tgt60", bp_target, BTB ? 32'h90 : 32'h0);
        // Same-cycle rewrite of the looked-up entry must not be seen yet
        train(32'h60, 32'hA0, 1'b1);
        step("pred60", BTB ? 32'h90 : 32'h64, 1'b0);
        idle();
        redir(2'b01, 32'h60, 32'h0, 32'h0);
        step("j60b", 32'h60, 1'b0);
        idle();
        check("bp_tgt60b", bp_target, BTB ? 32'hA0 : 32'h0);
        step("pred60b", BTB ? 32'hA0 : 32'h64, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
